// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and constants for the elevator car controller
package elevator_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVING    = 2'd1,
    S_ARRIVE    = 2'd2,
    S_DOOR_OPEN = 2'd3
  } car_state_t;

  typedef logic [1:0] floor_t;

  localparam floor_t FLOOR_BOTTOM = 2'd0;
  localparam floor_t FLOOR_TOP    = 2'd3;
  localparam logic   DIR_UP       = 1'b1;
  localparam logic   DIR_DOWN     = 1'b0;

endpackage

// File: rtl/elevator_car_ctrl_if.sv
// rtl/elevator_car_ctrl_if.sv - request/status bundle between memory manager and car controller
interface elevator_car_ctrl_if;
  import elevator_pkg::*;

  logic   OCRequest;
  logic   UDRequest;
  logic   MoveRequest;
  floor_t CurrentFloor;
  logic   UDIn;
  logic   Delay;
  logic   Moving;
  logic   DoorOpen;
  logic   Fault;

  modport master (
    output OCRequest, UDRequest, MoveRequest,
    input  CurrentFloor, UDIn, Delay, Moving, DoorOpen, Fault
  );

  modport slave (
    input  OCRequest, UDRequest, MoveRequest,
    output CurrentFloor, UDIn, Delay, Moving, DoorOpen, Fault
  );

endinterface

// File: rtl/elevator_timer.sv
// rtl/elevator_timer.sv - loadable down-counter shared by travel and door phases
module elevator_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Holds at zero so the count can never underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// rtl/elevator_car_ctrl.sv - car motion and door FSM with registered status outputs
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input logic              clk,
  input logic              rst_n,
  elevator_car_ctrl_if.slave car
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);

  car_state_t state_q, state_d;
  floor_t     floor_q, floor_d;
  logic       ud_q, ud_d;
  logic       delay_q, moving_q, door_q, fault_q, fault_d;
  logic       tmr_load, tmr_zero, legal_move;
  logic [TW-1:0] tmr_value;

  elevator_timer #(.WIDTH(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  // Refusing terminal-floor departures is what keeps the floor from wrapping.
  assign legal_move = car.MoveRequest
                    && !(car.UDRequest == DIR_UP   && floor_q == FLOOR_TOP)
                    && !(car.UDRequest == DIR_DOWN && floor_q == FLOOR_BOTTOM);

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    ud_d      = ud_q;
    fault_d   = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      S_IDLE, S_ARRIVE: begin
        if (car.OCRequest) begin
          state_d   = S_DOOR_OPEN;
          tmr_load  = 1'b1;
          tmr_value = DOOR_LOAD;
        end else if (legal_move) begin
          state_d   = S_MOVING;
          ud_d      = car.UDRequest;
          tmr_load  = 1'b1;
          tmr_value = TRAVEL_LOAD;
        end else begin
          state_d = S_IDLE;
          fault_d = car.MoveRequest;
        end
      end
      S_MOVING: begin
        if (tmr_zero) begin
          floor_d = (ud_q == DIR_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
          state_d = S_ARRIVE;
        end
      end
      S_DOOR_OPEN: begin
        if (car.OCRequest) begin
          tmr_load  = 1'b1;
          tmr_value = DOOR_LOAD;
        end else if (tmr_zero) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      floor_q  <= FLOOR_BOTTOM;
      ud_q     <= DIR_UP;
      delay_q  <= 1'b0;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      ud_q     <= ud_d;
      delay_q  <= (state_d == S_ARRIVE);
      moving_q <= (state_d == S_MOVING);
      door_q   <= (state_d == S_DOOR_OPEN);
      fault_q  <= fault_d;
    end
  end

  assign car.CurrentFloor = floor_q;
  assign car.UDIn         = ud_q;
  assign car.Delay        = delay_q;
  assign car.Moving       = moving_q;
  assign car.DoorOpen     = door_q;
  assign car.Fault        = fault_q;

endmodule
